// File: rtl/gmem_fill_pkg.sv
// Shared constants, FSM state type and address helper for the gmem_fill writer.
package gmem_fill_pkg;

  localparam int unsigned FB_W = 320;
  localparam int unsigned FB_H = 240;

  localparam logic [2:0] REG_CTRL  = 3'd0;
  localparam logic [2:0] REG_POS   = 3'd1;
  localparam logic [2:0] REG_SIZE  = 3'd2;
  localparam logic [2:0] REG_COLOR = 3'd3;
  localparam logic [2:0] REG_PIXEL = 3'd4;

  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_CLR_DONE = 1;
  localparam int unsigned CTRL_BUSY     = 0;
  localparam int unsigned CTRL_DONE     = 1;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  // y*320 + x as y*256 + y*64 + x
  function automatic logic [16:0] xy_to_addr(input logic [8:0] x, input logic [7:0] y);
    return {1'b0, y, 8'b0} + {3'b0, y, 6'b0} + {8'b0, x};
  endfunction

endpackage

// File: rtl/gmem_fill_engine.sv
// Rectangle fill engine: clips the request, walks the rectangle one pixel per cycle.
module gmem_fill_engine
  import gmem_fill_pkg::*;
#(
  parameter int unsigned ADDR_W  = 17,
  parameter int unsigned COLOR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [8:0]         x0,
  input  logic [7:0]         y0,
  input  logic [8:0]         w,
  input  logic [7:0]         h,
  input  logic [COLOR_W-1:0] color,
  output logic               busy,
  output logic               done_set,
  output logic               we,
  output logic [ADDR_W-1:0]  addr,
  output logic [COLOR_W-1:0] dat
);

  localparam logic [8:0]        X_LIM    = 9'(FB_W);
  localparam logic [7:0]        Y_LIM    = 8'(FB_H);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_W);

  state_t state, state_next;

  logic [8:0]         col, row, w_eff, h_eff;
  logic [ADDR_W-1:0]  row_base;
  logic [COLOR_W-1:0] fill_color;

  logic [8:0] x_room, w_clip;
  logic [7:0] y_room, h_clip;
  logic       degenerate, last_col, last_row, load;

  always_comb begin
    x_room     = X_LIM - x0;
    y_room     = Y_LIM - y0;
    w_clip     = (w < x_room) ? w : x_room;
    h_clip     = (h < y_room) ? h : y_room;
    // room values are only meaningful once the origin is known to be in range
    degenerate = (x0 >= X_LIM) || (y0 >= Y_LIM) || (w_clip == 9'd0) || (h_clip == 8'd0);
    last_col   = (col == w_eff - 9'd1);
    last_row   = (row == h_eff - 9'd1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    done_set   = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (degenerate) begin
            done_set = 1'b1;
          end else begin
            load       = 1'b1;
            state_next = FILL;
          end
        end
      end
      FILL: begin
        if (last_col && last_row) begin
          done_set   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col        <= '0;
      row        <= '0;
      w_eff      <= '0;
      h_eff      <= '0;
      row_base   <= '0;
      fill_color <= '0;
    end else if (load) begin
      col        <= '0;
      row        <= '0;
      w_eff      <= w_clip;
      h_eff      <= {1'b0, h_clip};
      row_base   <= ADDR_W'(xy_to_addr(x0, y0));
      fill_color <= color;
    end else if (state == FILL) begin
      if (last_col) begin
        col      <= '0;
        row      <= row + 9'd1;
        row_base <= row_base + ROW_STEP;
      end else begin
        col <= col + 9'd1;
      end
    end
  end

  assign busy = (state == FILL);
  assign we   = (state == FILL);
  assign addr = row_base + ADDR_W'(col);
  assign dat  = fill_color;

endmodule

// File: rtl/gmem_fill.sv
// Bus-slave graphics writer: register file, single-pixel path and gmem write-port mux.
module gmem_fill
  import gmem_fill_pkg::*;
#(
  parameter int unsigned ADDR_W  = 17,
  parameter int unsigned COLOR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bus_req,
  input  logic               bus_we,
  input  logic [4:0]         bus_addr,
  input  logic [31:0]        bus_dat_i,
  output logic [31:0]        bus_dat_o,
  output logic               bus_ready,
  output logic               gmem_we,
  output logic [ADDR_W-1:0]  gmem_addr,
  output logic [COLOR_W-1:0] gmem_dat,
  output logic               irq_done
);

  localparam logic [8:0] X_LIM = 9'(FB_W);
  localparam logic [7:0] Y_LIM = 8'(FB_H);

  logic [8:0]         pos_x, size_w;
  logic [7:0]         pos_y, size_h;
  logic [COLOR_W-1:0] color;
  logic               done;

  logic               pix_we;
  logic [ADDR_W-1:0]  pix_addr;
  logic [COLOR_W-1:0] pix_dat;

  logic               eng_busy, eng_done_set, eng_we;
  logic [ADDR_W-1:0]  eng_addr;
  logic [COLOR_W-1:0] eng_dat;

  logic [2:0]  sel;
  logic        wr, rd, wr_ctrl, wr_pixel, start, clr_done;
  logic [31:0] rdata;
  logic [8:0]  px;
  logic [7:0]  py;
  logic        unused_addr_lsbs;

  assign sel              = bus_addr[4:2];
  assign unused_addr_lsbs = ^bus_addr[1:0];
  // Only a PIXEL write can collide with the engine on the gmem port, so only it stalls.
  assign bus_ready        = !(bus_req && bus_we && (sel == REG_PIXEL) && eng_busy);
  assign wr               = bus_req && bus_ready && bus_we;
  assign rd               = bus_req && bus_ready && !bus_we;
  assign wr_ctrl          = wr && (sel == REG_CTRL);
  assign wr_pixel         = wr && (sel == REG_PIXEL);
  assign start            = wr_ctrl && bus_dat_i[CTRL_START];
  assign clr_done         = wr_ctrl && bus_dat_i[CTRL_CLR_DONE];
  assign px               = bus_dat_i[8:0];
  assign py               = bus_dat_i[16:9];

  gmem_fill_engine #(
    .ADDR_W  (ADDR_W),
    .COLOR_W (COLOR_W)
  ) u_engine (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .x0       (pos_x),
    .y0       (pos_y),
    .w        (size_w),
    .h        (size_h),
    .color    (color),
    .busy     (eng_busy),
    .done_set (eng_done_set),
    .we       (eng_we),
    .addr     (eng_addr),
    .dat      (eng_dat)
  );

  always_comb begin
    rdata = '0;
    case (sel)
      REG_CTRL:  rdata = {30'b0, done, eng_busy};
      REG_POS:   rdata = {8'b0, pos_y, 7'b0, pos_x};
      REG_SIZE:  rdata = {8'b0, size_h, 7'b0, size_w};
      REG_COLOR: rdata = 32'(color);
      default:   rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_x     <= '0;
      pos_y     <= '0;
      size_w    <= '0;
      size_h    <= '0;
      color     <= '0;
      done      <= 1'b0;
      bus_dat_o <= '0;
      pix_we    <= 1'b0;
      pix_addr  <= '0;
      pix_dat   <= '0;
    end else begin
      bus_dat_o <= rd ? rdata : '0;
      pix_we    <= 1'b0;
      if (wr && (sel == REG_POS)) begin
        pos_x <= bus_dat_i[8:0];
        pos_y <= bus_dat_i[23:16];
      end
      if (wr && (sel == REG_SIZE)) begin
        size_w <= bus_dat_i[8:0];
        size_h <= bus_dat_i[23:16];
      end
      if (wr && (sel == REG_COLOR)) color <= bus_dat_i[COLOR_W-1:0];
      if (wr_pixel) begin
        pix_we   <= (px < X_LIM) && (py < Y_LIM);
        pix_addr <= ADDR_W'(xy_to_addr(px, py));
        pix_dat  <= bus_dat_i[24 +: COLOR_W];
      end
      // set after clear so CLR_DONE+START with an empty rectangle still leaves DONE set
      if (clr_done)     done <= 1'b0;
      if (eng_done_set) done <= 1'b1;
    end
  end

  assign gmem_we   = eng_we || pix_we;
  assign gmem_addr = eng_we ? eng_addr : pix_addr;
  assign gmem_dat  = eng_we ? eng_dat  : pix_dat;
  assign irq_done  = done;

endmodule

// File: tb/tb_gmem_fill.sv
// Scoreboard bench for gmem_fill: expected gmem writes queued at stimulus, checked at output.
module tb_gmem_fill;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bus_req = 1'b0;
  logic        bus_we = 1'b0;
  logic [4:0]  bus_addr = '0;
  logic [31:0] bus_dat_i = '0;
  logic [31:0] bus_dat_o;
  logic        bus_ready;
  logic        gmem_we;
  logic [16:0] gmem_addr;
  logic [7:0]  gmem_dat;
  logic        irq_done;

  typedef struct {
    logic [16:0] addr;
    logic [7:0]  dat;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;

  gmem_fill #(.ADDR_W(17), .COLOR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_dat_i (bus_dat_i),
    .bus_dat_o (bus_dat_o),
    .bus_ready (bus_ready),
    .gmem_we   (gmem_we),
    .gmem_addr (gmem_addr),
    .gmem_dat  (gmem_dat),
    .irq_done  (irq_done)
  );

  always #5 clk = ~clk;

  // Write-port monitor: every gmem write must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst && gmem_we) begin
      wr_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL gmem_unexpected: got write addr=%0d dat=%02h, expected no write", gmem_addr, gmem_dat);
      end else begin
        e = exp_q.pop_front();
        if (gmem_addr !== e.addr || gmem_dat !== e.dat) begin
          n_fail++;
          $display("FAIL gmem_write: got addr=%0d dat=%02h, expected addr=%0d dat=%02h",
                   gmem_addr, gmem_dat, e.addr, e.dat);
        end
      end
    end
  end

  function automatic logic [31:0] xy(input int x, input int y);
    return {8'b0, 8'(y), 7'b0, 9'(x)};
  endfunction

  task automatic push_rect(input int x0, input int y0, input int w, input int h, input logic [7:0] c);
    for (int r = 0; r < h; r++)
      for (int k = 0; k < w; k++) begin
        wr_t e;
        e.addr = 17'((y0 + r) * 320 + x0 + k);
        e.dat  = c;
        exp_q.push_back(e);
      end
  endtask

  task automatic push_one(input int a, input logic [7:0] c);
    wr_t e;
    e.addr = 17'(a);
    e.dat  = c;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic bus_write_st(input logic [4:0] a, input logic [31:0] d, output int stalls);
    stalls    = 0;
    bus_req   = 1'b1;
    bus_we    = 1'b1;
    bus_addr  = a;
    bus_dat_i = d;
    forever begin
      @(negedge clk);
      if (bus_ready) break;
      stalls++;
      if (stalls > 2000) begin
        n_checks++;
        n_fail++;
        $display("FAIL bus_write_timeout: got bus_ready=0 for %0d cycles, expected acceptance", stalls);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus_req = 1'b0;
    bus_we  = 1'b0;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    int s;
    bus_write_st(a, d, s);
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    bus_req  = 1'b1;
    bus_we   = 1'b0;
    bus_addr = a;
    @(posedge clk);
    #1;
    bus_req = 1'b0;
    d = bus_dat_o;
  endtask

  task automatic wait_idle();
    logic [31:0] d;
    int i;
    for (i = 0; i < 1000; i++) begin
      bus_read(5'h00, d);
      if (d[0] == 1'b0) break;
    end
    if (i >= 1000) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle_timeout: got BUSY=1 after %0d polls, expected BUSY=0", i);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_q_empty(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: got %0d writes still outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_ctrl(input string name, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(5'h00, d);
    n_checks++;
    if (d !== exp) begin
      n_fail++;
      $display("FAIL %s: got CTRL=%08h, expected %08h", name, d, exp);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (gmem_we !== 1'b0 || gmem_addr !== '0 || gmem_dat !== '0 || irq_done !== 1'b0 || bus_dat_o !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got we=%b addr=%0d dat=%02h irq=%b rd=%08h, expected all 0",
               gmem_we, gmem_addr, gmem_dat, irq_done, bus_dat_o);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_ctrl("reset_ctrl", 32'h0);
    bus_read(5'h04, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_pos: got %08h, expected 00000000", d); end
    bus_read(5'h0C, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_color: got %08h, expected 00000000", d); end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus_dat_o !== 32'h0) begin n_fail++; $display("FAIL idle_rdata: got %08h, expected 00000000", bus_dat_o); end
  endtask

  task automatic test_pixel();
    logic [31:0] d;
    push_one(1605, 8'hE0);
    bus_write(5'h10, 32'hE000_0A05);
    n_checks++;
    if (gmem_we !== 1'b1) begin n_fail++; $display("FAIL pixel_latency: got gmem_we=%b, expected 1", gmem_we); end
    repeat (2) @(posedge clk);
    #1;
    check_q_empty("pixel_basic");
    bus_write(5'h10, 32'h5500_0140);
    bus_write(5'h10, 32'h5501_E000);
    push_one(76799, 8'h03);
    bus_write(5'h10, 32'h0301_DF3F);
    repeat (3) @(posedge clk);
    #1;
    check_q_empty("pixel_bounds");
    bus_read(5'h10, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL pixel_read: got %08h, expected 00000000", d); end
  endtask

  task automatic test_fill();
    bus_write(5'h04, xy(10, 2));
    bus_write(5'h08, xy(3, 2));
    bus_write(5'h0C, 32'h1C);
    push_rect(10, 2, 3, 2, 8'h1C);
    bus_write(5'h00, 32'h1);
    n_checks++;
    if (gmem_we !== 1'b1 || gmem_addr !== 17'd650) begin
      n_fail++;
      $display("FAIL fill_first: got we=%b addr=%0d, expected we=1 addr=650", gmem_we, gmem_addr);
    end
    wait_idle();
    check_q_empty("fill_basic");
    check_ctrl("fill_done", 32'h2);
    n_checks++;
    if (irq_done !== 1'b1) begin n_fail++; $display("FAIL fill_irq: got %b, expected 1", irq_done); end
    bus_write(5'h00, 32'h2);
    check_ctrl("clr_done", 32'h0);
  endtask

  task automatic test_clip();
    bus_write(5'h04, xy(318, 239));
    bus_write(5'h08, xy(10, 10));
    push_one(76798, 8'h1C);
    push_one(76799, 8'h1C);
    bus_write(5'h00, 32'h1);
    wait_idle();
    check_q_empty("clip_corner");
    check_ctrl("clip_done", 32'h2);
    bus_write(5'h00, 32'h2);
    bus_write(5'h04, xy(10, 2));
    bus_write(5'h08, xy(0, 10));
    bus_write(5'h00, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    check_q_empty("zero_width");
    check_ctrl("zero_width_done", 32'h2);
    bus_write(5'h00, 32'h2);
    bus_write(5'h04, xy(320, 0));
    bus_write(5'h08, xy(4, 4));
    bus_write(5'h00, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    check_q_empty("x_out_of_range");
    check_ctrl("x_oor_done", 32'h2);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    int stalls;
    bus_write(5'h00, 32'h2);
    bus_write(5'h04, xy(0, 0));
    bus_write(5'h08, xy(4, 3));
    bus_write(5'h0C, 32'h1C);
    push_rect(0, 0, 4, 3, 8'h1C);
    push_one(327, 8'hAA);
    bus_write(5'h00, 32'h1);
    bus_write(5'h0C, 32'h33);
    bus_write(5'h00, 32'h1);
    bus_write_st(5'h10, 32'hAA00_0207, stalls);
    n_checks++;
    if (stalls < 1 || stalls > 12) begin
      n_fail++;
      $display("FAIL pixel_stall: got %0d stall cycles, expected 1..12", stalls);
    end
    wait_idle();
    check_q_empty("stall_order");
    bus_read(5'h0C, d);
    n_checks++;
    if (d !== 32'h33) begin n_fail++; $display("FAIL color_update: got %08h, expected 00000033", d); end
  endtask

  task automatic test_reset_mid_fill();
    bus_write(5'h0C, 32'h5A);
    bus_write(5'h08, xy(20, 20));
    push_rect(0, 0, 20, 20, 8'h5A);
    bus_write(5'h00, 32'h1);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    n_checks++;
    if (gmem_we !== 1'b0 || gmem_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_abort: got we=%b addr=%0d, expected we=0 addr=0", gmem_we, gmem_addr);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_ctrl("after_reset", 32'h0);
    bus_write(5'h04, xy(1, 1));
    bus_write(5'h08, xy(2, 1));
    bus_write(5'h0C, 32'h44);
    push_rect(1, 1, 2, 1, 8'h44);
    bus_write(5'h00, 32'h1);
    wait_idle();
    check_q_empty("refill_small");
    bus_write(5'h08, xy(5, 2));
    push_rect(1, 1, 5, 2, 8'h44);
    bus_write(5'h00, 32'h3);
    check_ctrl("clr_start_busy", 32'h1);
    wait_idle();
    check_q_empty("clr_start_fill");
    check_ctrl("clr_start_done", 32'h2);
  endtask

  initial begin
    test_reset();
    test_pixel();
    test_fill();
    test_clip();
    test_back_to_back();
    test_reset_mid_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gmem_fill.md
Name: gmem_fill

Overview:
- Bus-slave graphics writer: the producer side of graphics memory. The VGA scan-out path only reads it.
- CPU software writes single pixels or starts a hardware rectangle fill.
- Block drives the gmem write port: 320x240 framebuffer, 8-bit colour, linear address = y*320 + x.
- Sits on the system bus beside the VGA controller; raises a done interrupt when a fill completes.

Parameters:
- FB_W, 320, framebuffer width in pixels.
- FB_H, 240, framebuffer height in rows.
- ADDR_W, 17, gmem address width.
- COLOR_W, 8, pixel width (RRRGGGBB).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- bus_req  in  1  bus access strobe, one cycle per access
- bus_we  in  1  1 = write, 0 = read
- bus_addr  in  5  byte offset; bits [4:2] select the register
- bus_dat_i  in  32  write data
- bus_dat_o  out  32  read data, registered
- bus_ready  out  1  access accepted this cycle
- gmem_we  out  1  gmem write enable
- gmem_addr  out  ADDR_W  gmem write address
- gmem_dat  out  COLOR_W  gmem write data
- irq_done  out  1  level interrupt; equals the DONE flag

Behaviour:
- Register map:
  - 0x00 CTRL. Write: bit0 START, bit1 CLR_DONE. Read: bit0 BUSY, bit1 DONE.
  - 0x04 POS: x = [8:0], y = [23:16].
  - 0x08 SIZE: w = [8:0], h = [23:16].
  - 0x0C COLOR: [7:0].
  - 0x10 PIXEL (write-only): x = [8:0], y = [16:9], colour = [31:24].
  - Any other offset, or a read of PIXEL, returns 0; writes to it are ignored.
- Reset: all registers 0, FSM IDLE, bus_dat_o 0, gmem_we 0, gmem_addr 0, gmem_dat 0, irq_done 0.
- Reads: bus_dat_o is valid the cycle after an accepted read. In any cycle without a read, bus_dat_o is 0.
- bus_ready:
  - 1 in every cycle except one: 0 while a PIXEL write is presented during FILL.
  - In that case the master holds the request; it is accepted in the first IDLE cycle.
- PIXEL write in IDLE, accepted in cycle N:
  - gmem_we = 1 in cycle N+1, with addr = y*320 + x and the given colour.
  - Out-of-range coordinate (x >= 320 or y >= 240): gmem_we stays 0 and the write is dropped silently.
- START in IDLE:
  - Latch the working copies: x0, y0, w, h, colour.
  - Clip: w_eff = min(w, 320 - x0), h_eff = min(h, 240 - y0).
  - If x0 or y0 is out of range, or w_eff or h_eff is 0, go to IDLE, set DONE, and write nothing.
  - Otherwise go to FILL. The start address is y0*256 + y0*64 + x0 (shift-add, no multiplier).
- FILL:
  - One pixel per cycle; gmem_we = 1 in every FILL cycle. The first write occurs the cycle after START.
  - Column counter runs 0..w_eff-1, then the row advances: row_base += 320.
  - After the last pixel (col = w_eff-1, row = h_eff-1), return to IDLE and set DONE in the same cycle as that last gmem_we.
  - Total FILL cycles = w_eff*h_eff.
- Writes to POS/SIZE/COLOR during FILL update the registers only; the running fill is unaffected.
- START during FILL is ignored.
- START and CLR_DONE in the same write: CLR_DONE is applied first, then START takes effect.
- DONE stays set until cleared by CLR_DONE.
- Reset asserted mid-fill aborts immediately with no further writes.
- Arithmetic: counters are 9 bits; addresses are ADDR_W bits. The maximum address is 76799, so no wrap is possible.

Decomposition:
- Package gmem_fill_pkg holds:
  - register offsets and CTRL bit indices;
  - FB_W/FB_H constants;
  - FSM enum {IDLE, FILL};
  - function xy_to_addr(x, y), shift-add form.
- One sub-module, gmem_fill_engine: clip, counters, address stepping, FSM.
- The top level keeps register decode, the PIXEL path and the write-port mux.

Test Plan:
- Reset, then read CTRL, POS and COLOR -> all 0; gmem_we never asserted.
- PIXEL write 0xE0_0_0A_05 (x = 5, y = 5, colour 0xE0) -> next cycle gmem_we = 1, addr = 1605, dat = 0xE0. A PIXEL write with x = 320 -> no write.
- POS (10, 2), SIZE (3, 2), COLOR 0x1C, START -> exactly 6 writes at 650, 651, 652, 970, 971, 972. Then BUSY = 0, DONE = 1, irq_done = 1.
- POS (318, 239), SIZE (10, 10) -> clipped to 2 writes: 76798, 76799. SIZE w = 0 -> DONE set with no writes.
- Issue a PIXEL write during a fill -> bus_ready = 0 until the fill ends, then the write is issued. Fill addresses are unchanged; a COLOR write mid-fill does not alter the fill colour.
- Assert rst mid-fill -> gmem_we drops immediately. After release: IDLE, DONE = 0. CLR_DONE+START in one write -> DONE ends 1 only after the new fill completes.
